counter_sequencer: RTL and testbench

//   Generates the one-cycle 'impulse' strobe that advances the LED counter.
//   Two raw push-buttons drive it. btn_mode toggles between PAUSE and RUN.
//   btn_step issues a single impulse while in PAUSE.
//   In RUN, a prescaler emits impulses at a rate chosen by rate_sel.

---
 rtl/counter_sequencer.sv | 143 ++++++++++++++
 tb/tb_counter_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - button-driven impulse sequencer with PAUSE/STEP/RUN control
//
// Purpose:
//   Turns two raw push-buttons into the one-cycle 'impulse' strobe that
//   advances the LED counter. btn_mode toggles between PAUSE and RUN.
//   btn_step gives a single impulse while paused. While running, a
//   prescaler emits impulses every max(TICK_DIV >> rate_sel, 1) cycles.
//
// Ports:
//   clk       in   1  system clock, posedge
//   nrst      in   1  asynchronous active-low reset
//   btn_mode  in   1  raw button, press toggles PAUSE/RUN
//   btn_step  in   1  raw button, press gives one impulse in PAUSE
//   rate_sel  in   2  RUN period select (TICK_DIV >> rate_sel)
//   impulse   out  1  registered one-cycle strobe
//   running   out  1  registered, high while in RUN

module counter_sequencer #(
  parameter int TICK_DIV        = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn_mode,
  input  logic       btn_step,
  input  logic [1:0] rate_sel,
  output logic       impulse,
  output logic       running
);

  localparam int PW = $clog2(TICK_DIV) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] TICK_DIV_W = PW'(TICK_DIV);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state, next_state;

  // Bit 0 = mode button, bit 1 = step button.
  logic [1:0] btn_raw;
  logic [1:0] btn_press;
  logic       mode_press;
  logic       step_press;

  assign btn_raw    = {btn_step, btn_mode};
  assign mode_press = btn_press[0];
  assign step_press = btn_press[1];

  // Per-button synchroniser + debouncer + rising-edge detector.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          cnt;
    logic                   deb;
    logic                   deb_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        sync_q <= '0;
        cnt    <= '0;
        deb    <= 1'b0;
        deb_d  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[b]};
        deb_d  <= deb;
        // Any cycle where the synchronised level agrees with the debounced
        // one restarts the count, so only an unbroken run can flip deb.
        if (s == deb) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          deb <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    // Only debounced rises count as presses; releases are silent.
    assign btn_press[b] = deb & ~deb_d;
  end

  // Prescaler terminal value; a shift result of 0 or 1 means every cycle.
  logic [PW-1:0] pre;
  logic [PW-1:0] div_shift;
  logic [PW-1:0] term;
  logic          tick;

  always_comb begin
    div_shift = TICK_DIV_W >> rate_sel;
    term      = (div_shift <= PW'(1)) ? '0 : div_shift - PW'(1);
    // '>=' lets a mid-run switch to a shorter period fire straight away.
    tick      = (state == RUN) && (pre >= term);
  end

  // Next-state logic. Mode press has priority over step press everywhere.
  always_comb begin
    next_state = state;
    case (state)
      PAUSE: begin
        if (mode_press)      next_state = RUN;
        else if (step_press) next_state = STEP;
      end
      STEP: begin
        next_state = mode_press ? RUN : PAUSE;
      end
      RUN: begin
        if (mode_press) next_state = PAUSE;
      end
      default: next_state = PAUSE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= PAUSE;
      pre     <= '0;
      impulse <= 1'b0;
      running <= 1'b0;
    end else begin
      state <= next_state;
      // Prescaler only counts while staying in RUN; entering or leaving
      // RUN always leaves it at zero.
      if ((state == RUN) && (next_state == RUN)) begin
        pre <= tick ? '0 : pre + PW'(1);
      end else begin
        pre <= '0;
      end
      // A RUN tick that lands on the exit press is dropped.
      impulse <= (next_state == STEP) | (tick & ~mode_press);
      running <= (next_state == RUN);
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer

module tb_counter_sequencer;

  logic       clk;
  logic       nrst;
  logic       btn_mode;
  logic       btn_step;
  logic [1:0] rate_sel;
  logic       impulse;
  logic       running;

  int cyc;
  int n_cmp;
  int n_fail;
  int exp_q[$];

  counter_sequencer #(
    .TICK_DIV       (8),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .btn_mode(btn_mode),
    .btn_step(btn_step),
    .rate_sel(rate_sel),
    .impulse (impulse),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance to just after posedge number c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every impulse seen must match the oldest expected cycle.
  always @(negedge clk) begin
    if (impulse === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_impulse: impulse at cycle %0d, expected none", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          n_fail++;
          $display("FAIL impulse_cycle: impulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    int k;
    nrst     = 1'b0;
    btn_mode = 1'b0;
    btn_step = 1'b0;
    rate_sel = 2'd0;

    // Test 1: reset values, then 200 idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check("reset_impulse", int'(impulse), 0);
    check("reset_running", int'(running), 0);
    nrst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      goto(cyc + 1);
      check("t1_running", int'(running), 0);
    end
    check_drained("t1_drained");

    // Test 2: step held 40 cycles -> one impulse 7 cycles after drive.
    k = cyc;
    btn_step = 1'b1;
    exp_q.push_back(k + 7);
    goto(k + 7);
    check("t2_running", int'(running), 0);
    goto(k + 40);
    btn_step = 1'b0;
    goto(k + 70);
    check_drained("t2_drained");

    // Test 3: step bouncing every 2 cycles never debounces.
    k = cyc;
    for (int i = 0; i < 15; i++) begin
      btn_step = ~btn_step;
      goto(cyc + 2);
    end
    btn_step = 1'b0;
    goto(k + 60);
    check_drained("t3_drained");

    // Test 4: RUN at rate 0, then rate 2, then rate 3, then exit.
    k = cyc;
    btn_mode = 1'b1;
    exp_q.push_back(k + 15);
    exp_q.push_back(k + 23);
    exp_q.push_back(k + 31);
    exp_q.push_back(k + 33);
    exp_q.push_back(k + 35);
    exp_q.push_back(k + 37);
    exp_q.push_back(k + 39);
    for (int c = 40; c <= 50; c++) exp_q.push_back(k + c);
    goto(k + 6);
    check("t4_running_before", int'(running), 0);
    goto(k + 10);
    btn_mode = 1'b0;
    goto(k + 14);
    check("t4_running", int'(running), 1);
    goto(k + 31);
    rate_sel = 2'd2;
    goto(k + 39);
    rate_sel = 2'd3;
    goto(k + 44);
    btn_mode = 1'b1;
    goto(k + 50);
    check("t4_running_last", int'(running), 1);
    goto(k + 51);
    check("t4_running_exit", int'(running), 0);
    goto(k + 54);
    btn_mode = 1'b0;
    rate_sel = 2'd0;
    goto(k + 80);
    check_drained("t4_drained");

    // Test 5: mode+step together, step ignored in RUN, exit on a tick.
    k = cyc;
    btn_mode = 1'b1;
    btn_step = 1'b1;
    exp_q.push_back(k + 15);
    exp_q.push_back(k + 23);
    exp_q.push_back(k + 31);
    exp_q.push_back(k + 39);
    goto(k + 8);
    check("t5_running", int'(running), 1);
    goto(k + 10);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    goto(k + 20);
    btn_step = 1'b1;
    goto(k + 30);
    btn_step = 1'b0;
    goto(k + 40);
    btn_mode = 1'b1;
    goto(k + 46);
    check("t5_running_last", int'(running), 1);
    goto(k + 48);
    check("t5_running_exit", int'(running), 0);
    goto(k + 50);
    btn_mode = 1'b0;
    goto(k + 90);
    check_drained("t5_drained");

    // Test 6: async reset mid-RUN with impulses every cycle.
    rate_sel = 2'd3;
    k = cyc;
    btn_mode = 1'b1;
    for (int c = 8; c <= 19; c++) exp_q.push_back(k + c);
    goto(k + 10);
    btn_mode = 1'b0;
    goto(k + 19);
    check("t6_running", int'(running), 1);
    goto(k + 20);
    nrst = 1'b0;
    #1;
    check("t6_async_impulse", int'(impulse), 0);
    check("t6_async_running", int'(running), 0);
    goto(k + 23);
    nrst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      goto(cyc + 1);
      check("t6_running_after", int'(running), 0);
    end
    check_drained("t6_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
